ldst_dataio_buffer: RTL and testbench

- Sits directly downstream of ALU3, the load/store execute port, on its data port.
- Decouples ALU3 from the data memory/MMU bus.
- Queues requests in a small FIFO, issues them in order to the memory side, and counts outstanding transactions.
- Returns in-order completions (load data or store ack) to ALU3 through a registered response stage.

---
 rtl/ldst_dataio_buffer_pkg.sv | 35 +++
 rtl/ldst_dataio_buffer_sync_fifo_sreset.sv | 58 +++++
 rtl/ldst_dataio_buffer.sv | 117 +++++++++++
 tb/tb_ldst_dataio_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_dataio_buffer_pkg.sv
// ldst_dataio_buffer_pkg
//   Shared definitions for the ALU3 load/store data-port buffer: access
//   ORDER encodings, request-bundle field widths and the packed request
//   bundle that is queued between ALU3 and the memory/MMU bus.
package ldst_dataio_buffer_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  localparam int ORDER_W  = 2;
  localparam int MASK_W   = 4;
  localparam int TID_W    = 14;
  localparam int MMUMOD_W = 2;
  localparam int WORD_W   = 32;
  localparam int OUT_W    = 4;   // outstanding counter width (max 15)

  // One queued memory request; field order is MSB..LSB of the FIFO word.
  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [MASK_W-1:0]   mask;
    logic                rw;
    logic [TID_W-1:0]    tid;
    logic [MMUMOD_W-1:0] mmumod;
    logic [WORD_W-1:0]   pdt;
    logic [WORD_W-1:0]   addr;
    logic [WORD_W-1:0]   data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/ldst_dataio_buffer_sync_fifo_sreset.sv
// sync_fifo_sreset
//   Synchronous FIFO, synchronous active-high reset. Storage is cleared on
//   reset so the head word reads zero while the FIFO is empty after reset.
//   Ports:
//     iCLOCK, iRESET_SYNC     clock / sync reset
//     iWR, iWR_DATA           write strobe and word (ignored when full)
//     iRD                     pop head (ignored when empty)
//     oRD_DATA                head word (no bypass from the write port)
//     oFULL, oEMPTY, oCOUNT   registered occupancy
module sync_fifo_sreset #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             iCLOCK,
  input  logic             iRESET_SYNC,
  input  logic             iWR,
  input  logic [WIDTH-1:0] iWR_DATA,
  input  logic             iRD,
  output logic [WIDTH-1:0] oRD_DATA,
  output logic             oFULL,
  output logic             oEMPTY,
  output logic [AW:0]      oCOUNT
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;
  logic [AW:0]                 cnt;
  logic                        wr_ok, rd_ok;

  assign oFULL    = (cnt == (AW+1)'(DEPTH));
  assign oEMPTY   = (cnt == '0);
  assign oCOUNT   = cnt;
  assign oRD_DATA = mem[rp];
  assign wr_ok    = iWR && !oFULL;
  assign rd_ok    = iRD && !oEMPTY;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= iWR_DATA;
        wp      <= wp + 1'b1;
      end
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ldst_dataio_buffer.sv
// ldst_dataio_buffer
//   Decouples ALU3's load/store data port from the memory/MMU bus. Requests
//   are queued, issued in order while the memory side is ready and fewer
//   than MAX_OUTSTANDING transactions are in flight, and in-order
//   completions are returned to ALU3 through a registered response stage.
//   Ports:
//     iCLOCK, iRESET_SYNC       clock / sync active-high reset
//     iDATAIO_* / oDATAIO_BUSY  request side from ALU3
//     oDATAIO_REQ/_DATA         one-cycle completion pulse + held load data
//     oMEM_* / iMEM_BUSY        request side to memory (FIFO head)
//     iMEM_VALID/_DATA          in-order completions from memory
//     oINFO_OUTSTANDING         in-flight count
//     oINFO_ERROR               sticky: completion seen with nothing in flight
module ldst_dataio_buffer
  import ldst_dataio_buffer_pkg::*;
#(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iDATAIO_REQ,
  output logic                oDATAIO_BUSY,
  input  logic [ORDER_W-1:0]  iDATAIO_ORDER,
  input  logic [MASK_W-1:0]   iDATAIO_MASK,
  input  logic                iDATAIO_RW,
  input  logic [TID_W-1:0]    iDATAIO_TID,
  input  logic [MMUMOD_W-1:0] iDATAIO_MMUMOD,
  input  logic [WORD_W-1:0]   iDATAIO_PDT,
  input  logic [WORD_W-1:0]   iDATAIO_ADDR,
  input  logic [WORD_W-1:0]   iDATAIO_DATA,
  output logic                oDATAIO_REQ,
  output logic [WORD_W-1:0]   oDATAIO_DATA,
  output logic                oMEM_REQ,
  input  logic                iMEM_BUSY,
  output logic [ORDER_W-1:0]  oMEM_ORDER,
  output logic [MASK_W-1:0]   oMEM_MASK,
  output logic                oMEM_RW,
  output logic [TID_W-1:0]    oMEM_TID,
  output logic [MMUMOD_W-1:0] oMEM_MMUMOD,
  output logic [WORD_W-1:0]   oMEM_PDT,
  output logic [WORD_W-1:0]   oMEM_ADDR,
  output logic [WORD_W-1:0]   oMEM_DATA,
  input  logic                iMEM_VALID,
  input  logic [WORD_W-1:0]   iMEM_DATA,
  output logic [OUT_W-1:0]    oINFO_OUTSTANDING,
  output logic                oINFO_ERROR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  req_t            push_req, head_req;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  logic            push, issue, cpl, spurious;
  logic [OUT_W-1:0] outstanding;

  assign push_req = '{order:  iDATAIO_ORDER,
                      mask:   iDATAIO_MASK,
                      rw:     iDATAIO_RW,
                      tid:    iDATAIO_TID,
                      mmumod: iDATAIO_MMUMOD,
                      pdt:    iDATAIO_PDT,
                      addr:   iDATAIO_ADDR,
                      data:   iDATAIO_DATA};

  assign push     = iDATAIO_REQ && !fifo_full;
  assign issue    = !fifo_empty && !iMEM_BUSY && (outstanding < MAX_OUT);
  // Completions only count against something actually in flight.
  assign cpl      = iMEM_VALID && (outstanding != '0);
  assign spurious = iMEM_VALID && (outstanding == '0);

  sync_fifo_sreset #(.WIDTH(REQ_W), .DEPTH(DEPTH), .AW(AW)) u_req_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iWR         (push),
    .iWR_DATA    (push_req),
    .iRD         (issue),
    .oRD_DATA    (head_req),
    .oFULL       (fifo_full),
    .oEMPTY      (fifo_empty),
    .oCOUNT      (fifo_count)
  );

  assign oDATAIO_BUSY = fifo_full;
  assign oMEM_REQ     = issue;
  assign oMEM_ORDER   = head_req.order;
  assign oMEM_MASK    = head_req.mask;
  assign oMEM_RW      = head_req.rw;
  assign oMEM_TID     = head_req.tid;
  assign oMEM_MMUMOD  = head_req.mmumod;
  assign oMEM_PDT     = head_req.pdt;
  assign oMEM_ADDR    = head_req.addr;
  assign oMEM_DATA    = head_req.data;
  assign oINFO_OUTSTANDING = outstanding;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      outstanding  <= '0;
      oDATAIO_REQ  <= 1'b0;
      oDATAIO_DATA <= '0;
      oINFO_ERROR  <= 1'b0;
    end else begin
      case ({issue, cpl})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      oDATAIO_REQ <= cpl;
      // Store acks also load the data register; ALU3 ignores it for stores.
      if (cpl) oDATAIO_DATA <= iMEM_DATA;
      if (spurious) oINFO_ERROR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldst_dataio_buffer.sv
module tb_ldst_dataio_buffer;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iDATAIO_REQ;
  logic        oDATAIO_BUSY;
  logic [1:0]  iDATAIO_ORDER;
  logic [3:0]  iDATAIO_MASK;
  logic        iDATAIO_RW;
  logic [13:0] iDATAIO_TID;
  logic [1:0]  iDATAIO_MMUMOD;
  logic [31:0] iDATAIO_PDT, iDATAIO_ADDR, iDATAIO_DATA;
  logic        oDATAIO_REQ;
  logic [31:0] oDATAIO_DATA;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic [1:0]  oMEM_ORDER;
  logic [3:0]  oMEM_MASK;
  logic        oMEM_RW;
  logic [13:0] oMEM_TID;
  logic [1:0]  oMEM_MMUMOD;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA;
  logic        iMEM_VALID;
  logic [31:0] iMEM_DATA;
  logic [3:0]  oINFO_OUTSTANDING;
  logic        oINFO_ERROR;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iCLOCK = ~iCLOCK;

  ldst_dataio_buffer #(.DEPTH(2), .MAX_OUTSTANDING(4)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
    .iDATAIO_REQ(iDATAIO_REQ), .oDATAIO_BUSY(oDATAIO_BUSY),
    .iDATAIO_ORDER(iDATAIO_ORDER), .iDATAIO_MASK(iDATAIO_MASK),
    .iDATAIO_RW(iDATAIO_RW), .iDATAIO_TID(iDATAIO_TID),
    .iDATAIO_MMUMOD(iDATAIO_MMUMOD), .iDATAIO_PDT(iDATAIO_PDT),
    .iDATAIO_ADDR(iDATAIO_ADDR), .iDATAIO_DATA(iDATAIO_DATA),
    .oDATAIO_REQ(oDATAIO_REQ), .oDATAIO_DATA(oDATAIO_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY),
    .oMEM_ORDER(oMEM_ORDER), .oMEM_MASK(oMEM_MASK), .oMEM_RW(oMEM_RW),
    .oMEM_TID(oMEM_TID), .oMEM_MMUMOD(oMEM_MMUMOD), .oMEM_PDT(oMEM_PDT),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
    .oINFO_OUTSTANDING(oINFO_OUTSTANDING), .oINFO_ERROR(oINFO_ERROR)
  );

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input logic [31:0] addr, input logic rw, input logic [31:0] data);
    iDATAIO_REQ  = 1'b1;
    iDATAIO_ADDR = addr;
    iDATAIO_RW   = rw;
    iDATAIO_DATA = data;
    iDATAIO_TID  = addr[13:0];
  endtask

  task automatic do_reset();
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
  endtask

  initial begin
    int issues, pushes, cyc;
    iRESET_SYNC = 1'b0; iDATAIO_REQ = 1'b0; iDATAIO_ORDER = 2'b10;
    iDATAIO_MASK = 4'hF; iDATAIO_RW = 1'b0; iDATAIO_TID = '0;
    iDATAIO_MMUMOD = 2'b01; iDATAIO_PDT = 32'h0000_8000;
    iDATAIO_ADDR = '0; iDATAIO_DATA = '0;
    iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = '0;

    // Reset state
    iRESET_SYNC = 1'b1; tick(); tick(); iRESET_SYNC = 1'b0;
    chk("rst_busy", 32'(oDATAIO_BUSY), 0);
    chk("rst_memreq", 32'(oMEM_REQ), 0);
    chk("rst_memaddr", oMEM_ADDR, 0);
    chk("rst_mempdt", oMEM_PDT, 0);
    chk("rst_out", 32'(oINFO_OUTSTANDING), 0);
    chk("rst_resp", 32'(oDATAIO_REQ), 0);
    chk("rst_rdata", oDATAIO_DATA, 0);
    chk("rst_err", 32'(oINFO_ERROR), 0);

    // Single load
    push_set(32'h0000_1000, 1'b0, 32'h0);
    tick(); iDATAIO_REQ = 1'b0;
    chk("ld_memreq", 32'(oMEM_REQ), 1);
    chk("ld_addr", oMEM_ADDR, 32'h0000_1000);
    chk("ld_pdt", oMEM_PDT, 32'h0000_8000);
    chk("ld_out0", 32'(oINFO_OUTSTANDING), 0);
    tick();
    chk("ld_out1", 32'(oINFO_OUTSTANDING), 1);
    chk("ld_memreq_off", 32'(oMEM_REQ), 0);
    tick(); tick();
    iMEM_VALID = 1'b1; iMEM_DATA = 32'hDEAD_BEEF;
    chk("ld_nopulse_yet", 32'(oDATAIO_REQ), 0);
    tick(); iMEM_VALID = 1'b0;
    chk("ld_out_back0", 32'(oINFO_OUTSTANDING), 0);
    chk("ld_pulse", 32'(oDATAIO_REQ), 1);
    chk("ld_rdata", oDATAIO_DATA, 32'hDEAD_BEEF);
    tick();
    chk("ld_pulse_end", 32'(oDATAIO_REQ), 0);
    chk("ld_rdata_hold", oDATAIO_DATA, 32'hDEAD_BEEF);

    // Back-pressure
    iMEM_BUSY = 1'b1;
    push_set(32'h10, 1'b1, 32'hAAAA_0010); tick();
    chk("bp_memreq_busy1", 32'(oMEM_REQ), 0);
    chk("bp_notfull", 32'(oDATAIO_BUSY), 0);
    push_set(32'h14, 1'b1, 32'hAAAA_0014); tick(); iDATAIO_REQ = 1'b0;
    chk("bp_full", 32'(oDATAIO_BUSY), 1);
    chk("bp_memreq_busy2", 32'(oMEM_REQ), 0);
    chk("bp_head", oMEM_ADDR, 32'h10);
    chk("bp_head_rw", 32'(oMEM_RW), 1);
    chk("bp_head_data", oMEM_DATA, 32'hAAAA_0010);
    iMEM_BUSY = 1'b0; #1;
    chk("bp_issue0", 32'(oMEM_REQ), 1);
    tick();
    chk("bp_busy_drop", 32'(oDATAIO_BUSY), 0);
    chk("bp_issue1", 32'(oMEM_REQ), 1);
    chk("bp_head1", oMEM_ADDR, 32'h14);
    chk("bp_head1_tid", 32'(oMEM_TID), 32'h14);
    chk("bp_out1", 32'(oINFO_OUTSTANDING), 1);
    tick();
    chk("bp_out2", 32'(oINFO_OUTSTANDING), 2);
    chk("bp_idle", 32'(oMEM_REQ), 0);
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h1; tick();
    chk("bp_ack1", 32'(oDATAIO_REQ), 1);
    iMEM_DATA = 32'h2; tick(); iMEM_VALID = 1'b0;
    chk("bp_ack2_data", oDATAIO_DATA, 32'h2);
    chk("bp_out_done", 32'(oINFO_OUTSTANDING), 0);

    // Outstanding cap: push 6 loads, never complete
    issues = 0; pushes = 0; cyc = 0;
    while (pushes < 6 && cyc < 20) begin
      if (!oDATAIO_BUSY) push_set(32'h100 + 32'(pushes) * 4, 1'b0, 32'h0);
      else iDATAIO_REQ = 1'b0;
      #1;
      if (oMEM_REQ) issues++;
      tick();
      if (iDATAIO_REQ) pushes++;
      cyc++;
    end
    iDATAIO_REQ = 1'b0;
    chk("cap_pushes", 32'(pushes), 6);
    chk("cap_issues", 32'(issues), 4);
    chk("cap_out4", 32'(oINFO_OUTSTANDING), 4);
    chk("cap_full", 32'(oDATAIO_BUSY), 1);
    chk("cap_noissue", 32'(oMEM_REQ), 0);
    chk("cap_head", oMEM_ADDR, 32'h110);
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h55; #1;
    chk("cap_noissue_on_valid", 32'(oMEM_REQ), 0);
    tick(); iMEM_VALID = 1'b0;
    chk("cap_out3", 32'(oINFO_OUTSTANDING), 3);
    chk("cap_pulse", 32'(oDATAIO_REQ), 1);
    chk("cap_issue5", 32'(oMEM_REQ), 1);
    chk("cap_issue5_addr", oMEM_ADDR, 32'h110);
    tick();
    chk("cap_out4b", 32'(oINFO_OUTSTANDING), 4);
    chk("cap_notfull", 32'(oDATAIO_BUSY), 0);
    chk("cap_head6", oMEM_ADDR, 32'h114);

    // Spurious completion after a fresh reset
    do_reset();
    chk("sp_out0", 32'(oINFO_OUTSTANDING), 0);
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h99; tick(); iMEM_VALID = 1'b0;
    chk("sp_nopulse", 32'(oDATAIO_REQ), 0);
    chk("sp_err", 32'(oINFO_ERROR), 1);
    chk("sp_out_still0", 32'(oINFO_OUTSTANDING), 0);
    tick();
    chk("sp_err_held", 32'(oINFO_ERROR), 1);
    chk("sp_rdata_kept", oDATAIO_DATA, 0);

    // Simultaneous push + issue + completion at count=1, outstanding=2
    push_set(32'h200, 1'b0, 0); tick();
    push_set(32'h204, 1'b0, 0); tick();
    push_set(32'h208, 1'b0, 0); tick();
    chk("sim_pre_out2", 32'(oINFO_OUTSTANDING), 2);
    chk("sim_pre_head", oMEM_ADDR, 32'h208);
    push_set(32'h20C, 1'b0, 0); iMEM_VALID = 1'b1; iMEM_DATA = 32'hCAFE_F00D; #1;
    chk("sim_issue", 32'(oMEM_REQ), 1);
    tick(); iDATAIO_REQ = 1'b0; iMEM_VALID = 1'b0;
    chk("sim_count1", 32'(oDATAIO_BUSY), 0);
    chk("sim_order", oMEM_ADDR, 32'h20C);
    chk("sim_out2", 32'(oINFO_OUTSTANDING), 2);
    chk("sim_pulse", 32'(oDATAIO_REQ), 1);
    chk("sim_rdata", oDATAIO_DATA, 32'hCAFE_F00D);

    // Reset mid-operation: 3 outstanding, 2 queued
    tick();
    iMEM_BUSY = 1'b1;
    push_set(32'h300, 1'b0, 0); tick();
    push_set(32'h304, 1'b0, 0); tick(); iDATAIO_REQ = 1'b0;
    chk("mid_out3", 32'(oINFO_OUTSTANDING), 3);
    chk("mid_full", 32'(oDATAIO_BUSY), 1);
    chk("mid_err_pre", 32'(oINFO_ERROR), 1);
    iMEM_BUSY = 1'b0;
    do_reset();
    chk("mid_out0", 32'(oINFO_OUTSTANDING), 0);
    chk("mid_busy0", 32'(oDATAIO_BUSY), 0);
    chk("mid_memreq0", 32'(oMEM_REQ), 0);
    chk("mid_addr0", oMEM_ADDR, 0);
    chk("mid_err0", 32'(oINFO_ERROR), 0);
    chk("mid_rdata0", oDATAIO_DATA, 0);
    iMEM_VALID = 1'b1; iMEM_DATA = 32'h7777; tick(); iMEM_VALID = 1'b0;
    chk("stale_nopulse", 32'(oDATAIO_REQ), 0);
    chk("stale_err", 32'(oINFO_ERROR), 1);
    chk("stale_out0", 32'(oINFO_OUTSTANDING), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
